// File: rtl/pixel_accum_rmw.sv
// pixel_accum_rmw
// Per-pixel read-modify-write accumulator. Each sample contributes
// (new - old) to a running sum that lives in external SRAM. Only the top
// STORE_W bits of the ACC_W-bit accumulator are stored, so a read brings
// back a coarse base with its low bits zeroed. INIT mode overwrites a pixel
// with the difference. ACCUM mode adds the difference to the stored value.
// Results are clamped to [0, 2^ACC_W - 1], and any clamp sets a sticky
// saturation flag.
module pixel_accum_rmw #(
  parameter int COLS    = 640,
  parameter int ROWS    = 480,
  parameter int STRIDE  = 640,
  parameter int ADDR_W  = 20,
  parameter int IN_W    = 35,
  parameter int ACC_W   = 40,
  parameter int STORE_W = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                    i_50M_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic                    i_stop,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [$clog2(COLS)-1:0] i_px,
  input  logic [$clog2(ROWS)-1:0] i_py,
  input  logic [IN_W-1:0]         i_new_data,
  input  logic [IN_W-1:0]         i_old_data,
  output logic [ADDR_W-1:0]       o_sram_addr,
  output logic                    o_sram_rd_en,
  input  logic [STORE_W-1:0]      i_sram_rdata,
  output logic                    o_sram_wr_en,
  output logic [STORE_W-1:0]      o_sram_wdata,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_sat
);

  localparam int PX_W  = $clog2(COLS);
  localparam int PY_W  = $clog2(ROWS);
  localparam int FRAME = COLS * ROWS;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int LOW_W = ACC_W - STORE_W;
  localparam int SUM_W = ACC_W + 2;

  localparam logic [PX_W:0]      COLS_L   = (PX_W + 1)'(COLS);
  localparam logic [PY_W:0]      ROWS_L   = (PY_W + 1)'(ROWS);
  localparam logic [CNT_W-1:0]   FRAME_L  = CNT_W'(FRAME);
  localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    READ,
    WAIT_RD,
    WRITE
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ACC_W:0]     diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic [STORE_W-1:0] wdata_q, wdata_d;

  logic               ready;
  logic               in_range;
  logic [ADDR_W-1:0]  addr_in;
  logic [ACC_W:0]     diff_in;
  logic [ACC_W-1:0]   base_sel;
  logic [ACC_W:0]     diff_sel;
  logic [SUM_W-1:0]   sum;
  logic               sum_neg;
  logic               sum_ovf;
  logic               sat_hit;
  logic [STORE_W-1:0] store_val;
  logic [CNT_W-1:0]   cnt_inc;
  logic               sum_unused;

  assign ready        = (state_q == WAIT_IN) && !i_stop;
  assign o_ready      = ready;
  assign o_sram_addr  = addr_q;
  assign o_sram_rd_en = rd_en_q;
  assign o_sram_wr_en = wr_en_q;
  assign o_sram_wdata = wdata_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_sat        = sat_q;

  // Decode the incoming sample: range check, SRAM address and signed difference.
  always_comb begin
    in_range = ({1'b0, i_px} < COLS_L) && ({1'b0, i_py} < ROWS_L);
    addr_in  = ADDR_W'(i_px) * ADDR_W'(STRIDE) + ADDR_W'(i_py);
    diff_in  = (ACC_W + 1)'(i_new_data) - (ACC_W + 1)'(i_old_data);
  end

  // Compute the clamped store value for whichever path is about to enter WRITE.
  // The sum has two guard bits so both underflow and overflow stay detectable.
  always_comb begin
    base_sel = '0;
    diff_sel = diff_in;
    if (state_q == WAIT_RD) begin
      diff_sel = diff_q;
      if (mode_q) begin
        base_sel = {i_sram_rdata, {LOW_W{1'b0}}};
      end
    end
    sum       = {2'b00, base_sel} + {diff_sel[ACC_W], diff_sel};
    sum_neg   = sum[SUM_W-1];
    sum_ovf   = !sum_neg && sum[ACC_W];
    sat_hit   = sum_neg || sum_ovf;
    store_val = sum[ACC_W-1 -: STORE_W];
    if (sum_neg) begin
      store_val = '0;
    end else if (sum_ovf) begin
      store_val = '1;
    end
    sum_unused = ^sum[LOW_W-1:0];
  end

  // Next-state logic for the frame controller and the single RMW in flight.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = WAIT_IN;
          mode_d  = i_mode;
          cnt_d   = '0;
          sat_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      WAIT_IN: begin
        if (i_valid && ready && in_range) begin
          addr_d = addr_in;
          diff_d = diff_in;
          if (mode_q) begin
            state_d = READ;
            rd_en_d = 1'b1;
          end else begin
            state_d = WRITE;
            wr_en_d = 1'b1;
            wdata_d = store_val;
            if (sat_hit) begin
              sat_d = 1'b1;
            end
          end
        end
      end

      READ: begin
        state_d = WAIT_RD;
        lat_d   = '0;
      end

      WAIT_RD: begin
        if (lat_q == LAT_LAST) begin
          state_d = WRITE;
          wr_en_d = 1'b1;
          wdata_d = store_val;
          if (sat_hit) begin
            sat_d = 1'b1;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == FRAME_L) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_IN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge i_50M_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_pixel_accum_rmw.sv
// tb_pixel_accum_rmw
// Directed plus randomized bench for pixel_accum_rmw on a small 5x4 frame
// with a three-cycle SRAM. A behavioural SRAM answers reads and absorbs
// writes. Expected store values come from plain integer arithmetic on a
// shadow copy of the pixel memory.
module tb_pixel_accum_rmw;

  localparam int COLS    = 5;
  localparam int ROWS    = 4;
  localparam int STRIDE  = 640;
  localparam int ADDR_W  = 20;
  localparam int IN_W    = 35;
  localparam int ACC_W   = 40;
  localparam int STORE_W = 16;
  localparam int RD_LAT  = 3;
  localparam int PX_W    = $clog2(COLS);
  localparam int PY_W    = $clog2(ROWS);
  localparam int SHIFT   = ACC_W - STORE_W;
  localparam int FRAME   = COLS * ROWS;

  logic               clk;
  logic               rst;
  logic               start;
  logic               mode;
  logic               stop;
  logic               valid;
  logic               ready;
  logic [PX_W-1:0]    px;
  logic [PY_W-1:0]    py;
  logic [IN_W-1:0]    new_data;
  logic [IN_W-1:0]    old_data;
  logic [ADDR_W-1:0]  sram_addr;
  logic               sram_rd_en;
  logic [STORE_W-1:0] sram_rdata = '0;
  logic               sram_wr_en;
  logic [STORE_W-1:0] sram_wdata;
  logic               busy;
  logic               frame_done;
  logic               sat;

  bit [15:0] sram    [4096];
  bit [15:0] ref_mem [4096];
  bit        pipe_v  [RD_LAT+1];
  int        pipe_a  [RD_LAT+1];
  bit        pl_en;
  int        pl_addr;
  bit [15:0] pl_val;

  int checks;
  int errors;
  bit model_mode;
  bit model_sat;
  int model_cnt;
  bit frame_seen;

  pixel_accum_rmw #(
    .COLS(COLS), .ROWS(ROWS), .STRIDE(STRIDE), .ADDR_W(ADDR_W),
    .IN_W(IN_W), .ACC_W(ACC_W), .STORE_W(STORE_W), .RD_LAT(RD_LAT)
  ) dut (
    .i_50M_clk   (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_mode      (mode),
    .i_stop      (stop),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_px        (px),
    .i_py        (py),
    .i_new_data  (new_data),
    .i_old_data  (old_data),
    .o_sram_addr (sram_addr),
    .o_sram_rd_en(sram_rd_en),
    .i_sram_rdata(sram_rdata),
    .o_sram_wr_en(sram_wr_en),
    .o_sram_wdata(sram_wdata),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_sat       (sat)
  );

  // 50 MHz clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural SRAM. Read data appears RD_LAT cycles after the strobe, and
  // random junk appears otherwise, so a mistimed capture is visible.
  always @(negedge clk) begin
    for (int k = RD_LAT; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_a[k] = pipe_a[k-1];
    end
    pipe_v[0] = sram_rd_en;
    pipe_a[0] = int'(sram_addr[11:0]);
    if (pipe_v[RD_LAT]) sram_rdata = sram[pipe_a[RD_LAT]];
    else                sram_rdata = 16'($urandom);
    if (sram_wr_en) sram[sram_addr[11:0]] = sram_wdata;
    if (pl_en)      sram[pl_addr] = pl_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: accumulate, clamp to the ACC_W range, keep the top bits.
  function automatic void refWrite(input bit accum, input longint stored, input longint nw,
                                   input longint od, output bit [15:0] wd, output bit s);
    longint sum;
    sum = (accum ? (stored << SHIFT) : 64'sd0) + nw - od;
    if (sum < 0) begin
      wd = 16'h0000; s = 1'b1;
    end else if (sum > ((longint'(1) << ACC_W) - 1)) begin
      wd = 16'hFFFF; s = 1'b1;
    end else begin
      wd = 16'(sum >> SHIFT); s = 1'b0;
    end
  endfunction

  function automatic longint rnd(input int bits);
    longint v;
    v = (longint'($urandom) << 32) | longint'($urandom);
    return v & ((longint'(1) << bits) - 1);
  endfunction

  task automatic preload(input int a, input bit [15:0] v);
    pl_addr = a;
    pl_val  = v;
    pl_en   = 1'b1;
    @(negedge clk);
    #1;
    pl_en      = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic startFrame(input bit m);
    mode  = m;
    start = 1'b1;
    tick();
    start      = 1'b0;
    model_mode = m;
    model_sat  = 1'b0;
    model_cnt  = 0;
    checkOutput("start_busy", 64'(busy), 64'd1);
    checkOutput("start_ready", 64'(ready), 64'd1);
    checkOutput("start_sat_clr", 64'(sat), 64'd0);
  endtask

  // One sample handshake followed by the full expected strobe timeline.
  task automatic applyStimulus(input int x, input int y, input longint nw, input longint od,
                               input bit stop_after);
    bit        inr;
    bit [15:0] wd;
    bit        s;
    int        a;
    inr      = (x < COLS) && (y < ROWS);
    px       = PX_W'(x);
    py       = PY_W'(y);
    new_data = IN_W'(nw);
    old_data = IN_W'(od);
    valid    = 1'b1;
    #1;
    checkOutput("ready_pre", 64'(ready), 64'd1);
    tick();
    valid = 1'b0;
    if (stop_after) stop = 1'b1;
    if (!inr) begin
      checkOutput("oor_rd", 64'(sram_rd_en), 64'd0);
      checkOutput("oor_wr", 64'(sram_wr_en), 64'd0);
      checkOutput("oor_ready", 64'(ready), 64'd1);
      return;
    end
    a = x * STRIDE + y;
    refWrite(model_mode, longint'(ref_mem[a]), nw, od, wd, s);
    if (model_mode) begin
      checkOutput("rd_strobe", 64'(sram_rd_en), 64'd1);
      checkOutput("rd_addr", 64'(sram_addr), 64'(a));
      checkOutput("rd_no_wr", 64'(sram_wr_en), 64'd0);
      for (int k = 0; k < RD_LAT; k++) begin
        tick();
        checkOutput("wait_rd_rd", 64'(sram_rd_en), 64'd0);
        checkOutput("wait_rd_wr", 64'(sram_wr_en), 64'd0);
      end
      tick();
    end
    model_sat = model_sat | s;
    checkOutput("wr_strobe", 64'(sram_wr_en), 64'd1);
    checkOutput("wr_no_rd", 64'(sram_rd_en), 64'd0);
    checkOutput("wr_addr", 64'(sram_addr), 64'(a));
    checkOutput("wr_data", 64'(sram_wdata), 64'(wd));
    checkOutput("wr_sat", 64'(sat), 64'(model_sat));
    checkOutput("wr_busy", 64'(busy), 64'd1);
    ref_mem[a] = wd;
    model_cnt++;
    tick();
    checkOutput("post_wr", 64'(sram_wr_en), 64'd0);
    if (model_cnt == FRAME) begin
      frame_seen = 1'b1;
      checkOutput("done_pulse", 64'(frame_done), 64'd1);
      checkOutput("done_busy", 64'(busy), 64'd0);
      checkOutput("done_ready", 64'(ready), 64'd0);
      tick();
      checkOutput("done_once", 64'(frame_done), 64'd0);
      model_cnt = 0;
    end else begin
      checkOutput("no_done", 64'(frame_done), 64'd0);
      checkOutput("ready_post", 64'(ready), 64'(!stop));
    end
  endtask

  initial begin
    int guard;
    checks = 0; errors = 0; model_cnt = 0; model_sat = 0; model_mode = 0;
    frame_seen = 0; pl_en = 0; pl_addr = 0; pl_val = '0;
    rst = 1'b1; start = 0; mode = 0; stop = 0; valid = 0;
    px = '0; py = '0; new_data = '0; old_data = '0;
    tick();
    tick();
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rd", 64'(sram_rd_en), 64'd0);
    checkOutput("rst_wr", 64'(sram_wr_en), 64'd0);
    checkOutput("rst_sat", 64'(sat), 64'd0);
    checkOutput("rst_done", 64'(frame_done), 64'd0);
    checkOutput("rst_addr", 64'(sram_addr), 64'd0);
    checkOutput("rst_wdata", 64'(sram_wdata), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_ready", 64'(ready), 64'd0);

    // INIT frame: directed sample, one rejected pixel, then random fill to frame end.
    startFrame(1'b0);
    applyStimulus(1, 2, longint'(3) << 24, longint'(1) << 24, 1'b0);
    applyStimulus(5, 1, longint'(7) << 24, 0, 1'b0);
    guard = 0;
    while (!frame_seen && guard < 200) begin
      applyStimulus($urandom_range(7, 0), $urandom_range(3, 0), rnd(34), rnd(34), 1'b0);
      guard++;
    end
    checkOutput("frame_seen", 64'(frame_seen), 64'd1);
    tick();
    checkOutput("idle_after_frame", 64'(busy), 64'd0);

    // ACCUM frame: plain add, overflow, sticky flag, underflow, random.
    startFrame(1'b1);
    preload(3, 16'h0002);
    applyStimulus(0, 3, longint'(5) << 24, 0, 1'b0);
    preload(641, 16'hFFFF);
    applyStimulus(1, 1, longint'(1) << 24, 0, 1'b0);
    applyStimulus(0, 3, longint'(1) << 24, 0, 1'b0);
    preload(1282, 16'h0001);
    applyStimulus(2, 2, 0, longint'(3) << 24, 1'b0);
    for (int n = 0; n < 5; n++) begin
      applyStimulus($urandom_range(4, 0), $urandom_range(3, 0), rnd(31), rnd(31), 1'b0);
    end

    // Stop raised right after a handshake: RMW completes, then acceptance pauses.
    applyStimulus(4, 0, rnd(30), rnd(30), 1'b1);
    valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("stop_ready", 64'(ready), 64'd0);
      checkOutput("stop_no_rd", 64'(sram_rd_en), 64'd0);
    end
    valid = 1'b0;
    stop  = 1'b0;
    #1;
    checkOutput("stop_release", 64'(ready), 64'd1);
    applyStimulus(3, 1, rnd(30), rnd(30), 1'b0);

    // Reset while waiting on read data: nothing may be written afterwards.
    px = PX_W'(2); py = PY_W'(1); new_data = IN_W'(rnd(30)); old_data = '0;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    checkOutput("rr_rd", 64'(sram_rd_en), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rr_ready", 64'(ready), 64'd0);
    checkOutput("rr_busy", 64'(busy), 64'd0);
    checkOutput("rr_wr", 64'(sram_wr_en), 64'd0);
    checkOutput("rr_sat", 64'(sat), 64'd0);
    checkOutput("rr_addr", 64'(sram_addr), 64'd0);
    checkOutput("rr_wdata", 64'(sram_wdata), 64'd0);
    for (int n = 0; n < 6; n++) begin
      tick();
      checkOutput("rr_no_wr", 64'(sram_wr_en), 64'd0);
      checkOutput("rr_idle", 64'(busy), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
